// File: rtl/program_loader_memory_if.sv
// Byte-stream load channel feeding the program memory.
// The loader has no backpressure; byteReady is always high.
interface program_loader_memory_if;
    logic [7:0] byteIn;
    logic       byteValid;
    logic       byteReady;

    modport master (
        output byteIn,
        output byteValid,
        input  byteReady
    );

    modport slave (
        input  byteIn,
        input  byteValid,
        output byteReady
    );
endinterface

// File: rtl/program_loader_memory.sv
// Instruction memory with a framed byte-stream loader.
// Fetch is parked on the reset opcode until a full program is in.
module program_loader_memory #(
    parameter int unsigned PC_WIDTH          = 4,
    parameter int unsigned INSTRUCTION_WIDTH = 16,
    parameter logic [3:0]  RESET_OPCODE      = 4'd4
) (
    input  logic                         clock,
    input  logic                         reset,
    program_loader_memory_if.slave       bus,
    input  logic [PC_WIDTH-1:0]          pc,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         running,
    output logic                         loadError,
    output logic [PC_WIDTH:0]            wordsLoaded
);

    localparam int unsigned IW    = INSTRUCTION_WIDTH;
    localparam int unsigned BYTES = IW / 8;
    localparam int unsigned DEPTH = 2 ** PC_WIDTH;
    localparam int unsigned BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BIW-1:0]      LAST_BYTE = BIW'(BYTES - 1);
    localparam logic [BIW-1:0]      BI_ONE    = BIW'(1);
    localparam logic [PC_WIDTH-1:0] WI_ONE    = PC_WIDTH'(1);
    localparam logic [PC_WIDTH:0]   N_ONE     = (PC_WIDTH + 1)'(1);
    localparam logic [IW-1:0]       PARKED    =
        {RESET_OPCODE, {(IW - 4){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        ERROR
    } state_t;

    state_t               state_q, state_d;
    logic [PC_WIDTH:0]    n_q, n_d;
    logic [PC_WIDTH-1:0]  wordIndex_q, wordIndex_d;
    logic [BIW-1:0]       byteIndex_q, byteIndex_d;
    logic [IW-1:0]        assembly_q, assembly_d;
    logic [PC_WIDTH:0]    wordsLoaded_q, wordsLoaded_d;
    logic                 running_q, running_d;
    logic                 loadError_q, loadError_d;

    logic [IW-1:0]        mem [DEPTH];
    logic [IW-1:0]        asmNext;
    logic                 countLegal;
    logic                 lastWord;
    logic                 we;

    assign bus.byteReady = 1'b1;

    // Shift form keeps this valid when a word is a single byte.
    assign asmNext    = (assembly_q << 8) | IW'(bus.byteIn);
    assign countLegal = (bus.byteIn != 8'd0) &&
                        (32'(bus.byteIn) <= DEPTH);
    assign lastWord   = ({1'b0, wordIndex_q} == (n_q - N_ONE));

    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        wordIndex_d   = wordIndex_q;
        byteIndex_d   = byteIndex_q;
        assembly_d    = assembly_q;
        wordsLoaded_d = wordsLoaded_q;
        running_d     = running_q;
        loadError_d   = loadError_q;
        we            = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (bus.byteValid) begin
                    assembly_d = asmNext;
                    if (byteIndex_q == LAST_BYTE) begin
                        we            = 1'b1;
                        byteIndex_d   = '0;
                        wordIndex_d   = wordIndex_q + WI_ONE;
                        wordsLoaded_d = wordsLoaded_q + N_ONE;
                        if (lastWord) begin
                            state_d   = RUN;
                            running_d = 1'b1;
                        end
                    end else begin
                        byteIndex_d = byteIndex_q + BI_ONE;
                    end
                end
            end
            default: begin
                // IDLE, RUN and ERROR all treat a byte as a new count.
                if (bus.byteValid) begin
                    running_d = 1'b0;
                    if (countLegal) begin
                        state_d       = LOAD;
                        n_d           = (PC_WIDTH + 1)'(bus.byteIn);
                        wordIndex_d   = '0;
                        byteIndex_d   = '0;
                        wordsLoaded_d = '0;
                        assembly_d    = '0;
                        loadError_d   = 1'b0;
                    end else begin
                        state_d     = ERROR;
                        loadError_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            n_q           <= '0;
            wordIndex_q   <= '0;
            byteIndex_q   <= '0;
            assembly_q    <= '0;
            wordsLoaded_q <= '0;
            running_q     <= 1'b0;
            loadError_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            wordIndex_q   <= wordIndex_d;
            byteIndex_q   <= byteIndex_d;
            assembly_q    <= assembly_d;
            wordsLoaded_q <= wordsLoaded_d;
            running_q     <= running_d;
            loadError_q   <= loadError_d;
        end
    end

    // Array is deliberately left uncleared by reset.
    always_ff @(posedge clock) begin
        if (!reset && we) begin
            mem[wordIndex_q] <= asmNext;
        end
    end

    assign instruction = (state_q == RUN) ? mem[pc] : PARKED;
    assign running     = running_q;
    assign loadError   = loadError_q;
    assign wordsLoaded = wordsLoaded_q;

endmodule

// File: tb/tb_program_loader_memory.sv
// Randomized scoreboard bench for program_loader_memory.
// A frame-level model predicts every cycle's outputs.
module tb_program_loader_memory;

    logic       clk;
    logic       rst;
    logic [3:0] pcv;
    logic [15:0] instr;
    logic       run_o;
    logic       err_o;
    logic [4:0] words_o;

    program_loader_memory_if bus_if ();

    program_loader_memory dut (
        .clock       (clk),
        .reset       (rst),
        .bus         (bus_if.slave),
        .pc          (pcv),
        .instruction (instr),
        .running     (run_o),
        .loadError   (err_o),
        .wordsLoaded (words_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          run;
        bit          err;
        logic [4:0]  words;
        bit          chk_instr;
        logic [15:0] instr;
    } exp_t;

    exp_t sb [$];

    int n_checks = 0;
    int n_errors = 0;

    bit          m_run;
    bit          m_err;
    bit          m_loading;
    int          m_n;
    int          m_cnt;
    int          m_words;
    logic [7:0]  m_hi;
    logic [15:0] m_mem   [16];
    bit          m_known [16];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Frame semantics: count byte, then 2 bytes per word, MSB first.
    task automatic model_step(bit r, bit v, logic [7:0] b);
        if (r) begin
            m_run = 0;
            m_err = 0;
            m_loading = 0;
            m_words = 0;
        end else if (v) begin
            if (m_loading) begin
                m_cnt++;
                if (m_cnt % 2 == 1) begin
                    m_hi = b;
                end else begin
                    m_mem[m_cnt / 2 - 1] = {m_hi, b};
                    m_known[m_cnt / 2 - 1] = 1;
                    m_words++;
                    if (m_words == m_n) begin
                        m_loading = 0;
                        m_run = 1;
                    end
                end
            end else if (b == 8'd0 || b > 8'd16) begin
                m_err = 1;
                m_run = 0;
            end else begin
                m_n = int'(b);
                m_loading = 1;
                m_run = 0;
                m_err = 0;
                m_cnt = 0;
                m_words = 0;
            end
        end
    endtask

    task automatic cyc(bit r, bit v, logic [7:0] b, logic [3:0] p);
        exp_t e;
        rst = r;
        bus_if.byteValid = v;
        bus_if.byteIn = b;
        pcv = p;
        e.run = m_run;
        e.err = m_err;
        e.words = 5'(m_words);
        e.chk_instr = !m_run || m_known[p];
        e.instr = m_run ? m_mem[p] : 16'h4000;
        sb.push_back(e);
        @(posedge clk);
        #1;
        model_step(r, v, b);
    endtask

    task automatic send(logic [7:0] b);
        cyc(0, 1, b, 4'($urandom_range(0, 15)));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 8'($urandom), 4'($urandom_range(0, 15)));
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("running", 32'(run_o), 32'(e.run));
            check("loadError", 32'(err_o), 32'(e.err));
            check("wordsLoaded", 32'(words_o), 32'(e.words));
            check("byteReady", 32'(bus_if.byteReady), 32'd1);
            if (e.chk_instr)
                check("instruction", 32'(instr), 32'(e.instr));
        end
    end

    initial begin
        rst = 1'b1;
        bus_if.byteValid = 1'b0;
        bus_if.byteIn = 8'd0;
        pcv = '0;
        m_run = 0;
        m_err = 0;
        m_loading = 0;
        m_n = 0;
        m_cnt = 0;
        m_words = 0;
        m_hi = '0;
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = '0;
            m_known[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;

        // reset state and parked fetch before any load
        cyc(1, 0, 8'h00, 4'd0);
        cyc(1, 1, 8'h02, 4'd7);
        idle(4);

        // full-depth load, N == 16
        send(8'h10);
        for (int i = 0; i < 32; i++) send(8'($urandom));
        idle(4);

        // basic two-word frame
        cyc(1, 0, 8'h00, 4'd0);
        send(8'h02);
        send(8'h00);
        send(8'h05);
        send(8'h40);
        send(8'h00);
        cyc(0, 0, 8'h00, 4'd0);
        cyc(0, 0, 8'h00, 4'd1);
        idle(2);

        // illegal counts, then recovery
        send(8'h00);
        idle(2);
        send(8'h11);
        idle(1);
        send(8'hFF);
        idle(1);
        send(8'h01);
        send(8'h12);
        send(8'h34);
        cyc(0, 0, 8'h00, 4'd0);
        idle(1);

        // gaps inside a word
        send(8'h01);
        send(8'h56);
        idle(3);
        send(8'h78);
        cyc(0, 0, 8'h00, 4'd0);

        // reset mid-frame with a coincident valid byte
        send(8'h02);
        send(8'h11);
        send(8'h22);
        cyc(1, 1, 8'h33, 4'd0);
        idle(1);
        send(8'h01);
        send(8'h99);
        send(8'h88);
        cyc(0, 0, 8'h00, 4'd0);

        // reload while running
        send(8'h01);
        send(8'hAB);
        send(8'hCD);
        cyc(0, 0, 8'h00, 4'd0);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit r;
            bit v;
            logic [7:0] b;
            int k;
            r = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 9) < 7);
            if (m_loading) begin
                b = 8'($urandom);
            end else begin
                k = int'($urandom_range(0, 9));
                if (k == 0) b = 8'h00;
                else if (k == 1) b = 8'($urandom_range(17, 255));
                else b = 8'($urandom_range(1, 16));
            end
            cyc(r, v, b, 4'($urandom_range(0, 15)));
        end
        idle(3);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/program_loader_memory.md
Name: program_loader_memory

Overview:
- Instruction-memory responder at the fetch end of the CPU. The CPU drives pc; this block returns instruction combinationally.
- Adds a byte-stream loader (valid/ready) that writes a program into the memory array.
- While no complete program is loaded, the fetch output is forced to the RESET opcode, so the CPU stays parked at pc 0 with accumulator 0.

Parameters:
- PC_WIDTH, 4, fetch address width; memory depth = 2**PC_WIDTH words.
- INSTRUCTION_WIDTH, 16, word width; must be a multiple of 8.
- RESET_OPCODE, 4'd4, opcode placed in instruction[INSTRUCTION_WIDTH-1 -: 4] while parked.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- byteIn  input  8  load stream data.
- byteValid  input  1  byteIn valid this cycle.
- byteReady  output  1  block accepts byteIn this cycle.
- pc  input  PC_WIDTH  fetch address from CPU.
- instruction  output  INSTRUCTION_WIDTH  fetched word (combinational from pc).
- running  output  1  a complete program is loaded; fetch path is live.
- loadError  output  1  last count byte was illegal.
- wordsLoaded  output  PC_WIDTH+1  words written in current/last load.

Behaviour:
- BYTES = INSTRUCTION_WIDTH/8. A byte is accepted on a posedge with byteValid && byteReady.
- byteReady is 1 in every state; there is no backpressure.
- Frame format: one count byte N, followed by N*BYTES data bytes. Each word is sent MSB byte first. Word i is written to mem[i].

States:
- IDLE: entered on reset.
  - Accepted byte is N.
  - N==0 or N>2**PC_WIDTH -> ERROR.
  - Otherwise latch N, clear wordIndex, byteIndex and wordsLoaded, then go to LOAD.
- LOAD:
  - Each accepted byte shifts into the assembly register; byteIndex increments.
  - On the byte with byteIndex==BYTES-1, mem[wordIndex] is written with {assembly, byteIn} on that same edge.
  - Then wordIndex++, wordsLoaded++, byteIndex=0.
  - If wordIndex==N-1 at that write -> RUN.
  - Cycles without byteValid hold all state.
- RUN: an accepted byte is treated as a new N, same rules as IDLE. A legal N goes to LOAD; an illegal N goes to ERROR.
- ERROR: an accepted byte is treated as a new N, same rules as IDLE.

Outputs:
- instruction = mem[pc] when state==RUN. Otherwise it is {RESET_OPCODE, zeros}, i.e. 16'h4000 at defaults.
- running = (state==RUN); 1 from the cycle after the edge that writes the last word.
- loadError = (state==ERROR).

Reset values: state IDLE, running 0, loadError 0, wordsLoaded 0, byteIndex 0, wordIndex 0, byteReady 1.
- Memory contents are not cleared by reset.
- Reset during LOAD abandons the frame. Partially written words remain in memory, but the output is parked.
- Reset has priority over a simultaneous byte accept; that byte is dropped.

Width and boundary rules:
- wordsLoaded counts up to 2**PC_WIDTH without wrap. N==2**PC_WIDTH is legal and fills the whole array.
- A pc outside the loaded range in RUN returns the stale memory contents; this is not an error.
- Write and read in the same cycle: a new word is visible on instruction only from the next cycle, since the block is not in RUN during LOAD.

Test Plan:
- Reset, then byteIn 0x02,0x00,0x05,0x40,0x00 on consecutive cycles -> mem[0]=16'h0005, mem[1]=16'h4000. running rises the cycle after the 5th byte. pc=0 -> instruction 16'h0005; pc=1 -> 16'h4000. wordsLoaded=2.
- Before any load, and during a load, any pc -> instruction 16'h4000 and running=0.
- Count byte 0x00 -> loadError=1 next cycle. Count 0x11 (17 > 16) -> loadError=1. A following count 0x01 plus 0x12,0x34 -> loadError=0, running=1, mem[0]=16'h1234.
- Load N=1 with byteValid deasserted for 3 cycles between the data bytes -> result is identical to the back-to-back case; wordsLoaded stays 0 until the second data byte.
- reset asserted after 3 of 5 bytes, coincident with a valid byte -> state IDLE, running=0, wordsLoaded=0, byte dropped. The next byte is interpreted as a count.
- While running, send 0x01,0xAB,0xCD -> running drops the cycle after the count byte and instruction is 16'h4000 during the load. Afterwards running=1 and mem[0]=16'hABCD.
